// File: rtl/relock_scan_ramp_pkg.sv
// Shared types and constants for the relock scan ramp generator.
// State encodings are fixed so CSR and debug readback decode them identically.
package relock_scan_ramp_pkg;

    localparam int SCAN_R     = 14;
    localparam int SCAN_DIV_W = 16;
    localparam int ST_W       = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } scan_state_t;

    // True in the two states where the ramp is actively driving scan_out.
    function automatic logic is_ramp(input scan_state_t st);
        return (st == ST_UP) || (st == ST_DOWN);
    endfunction

endpackage

// File: rtl/relock_scan_ramp_if.sv
// Controller <-> scan ramp signal bundle; the controller is the master.
interface relock_scan_ramp_if
    import relock_scan_ramp_pkg::*;
#(
    parameter int R     = SCAN_R,
    parameter int DIV_W = SCAN_DIV_W
) ();

    logic                run_scan;
    logic [R-1:0]        scan_A;
    logic [R-1:0]        low_lim;
    logic [R-1:0]        hig_lim;
    logic [R-2:0]        step;
    logic [DIV_W-1:0]    divider;
    logic [R-1:0]        scan_out;
    logic                scan_trigger;
    logic                scan_dir;
    logic                lim_err;

    modport master (
        output run_scan, scan_A, low_lim, hig_lim, step, divider,
        input  scan_out, scan_trigger, scan_dir, lim_err
    );

    modport slave (
        input  run_scan, scan_A, low_lim, hig_lim, step, divider,
        output scan_out, scan_trigger, scan_dir, lim_err
    );

endinterface

// File: rtl/relock_scan_ramp_satprotect.sv
// Signed saturation: clamps a Ri-bit value into the SAT-bit signed range,
// then sign-extends the result to Ro bits.
module satprotect #(
    parameter int Ri  = 15,
    parameter int Ro  = 14,
    parameter int SAT = 14
) (
    input  logic [Ri-1:0] din,
    output logic [Ro-1:0] dout
);

    logic [SAT-1:0]   sat_v;
    logic [Ri-SAT:0]  top_bits;

    assign top_bits = din[Ri-1:SAT-1];

    // The value fits when every bit above the SAT-bit sign position matches it.
    always_comb begin
        sat_v = din[SAT-1:0];
        if (!((&top_bits) || (~|top_bits))) begin
            sat_v = din[Ri-1] ? {1'b1, {(SAT-1){1'b0}}} : {1'b0, {(SAT-1){1'b1}}};
        end
    end

    assign dout = Ro'($signed(sat_v));

endmodule

// File: rtl/relock_scan_ramp.sv
// Triangular scan generator: ramps scan_out between live limits, pulses scan_trigger
// at every low-limit turn, and tracks scan_A while idle for a bumpless hand-over.
module relock_scan_ramp
    import relock_scan_ramp_pkg::*;
#(
    parameter int R     = SCAN_R,
    parameter int DIV_W = SCAN_DIV_W
) (
    input logic               clk,
    input logic               rstn,
    relock_scan_ramp_if.slave bus
);

    scan_state_t        state_q, state_n;
    logic [R-1:0]       scan_q, scan_n;
    logic               trig_q, trig_n;
    logic               dir_q, dir_n;
    logic               err_q, err_n;
    logic [DIV_W-1:0]   cnt_q, cnt_n;

    logic [R:0]         sum_w, dif_w;
    logic [R-1:0]       up_sat, dn_sat;
    logic               up_hit, dn_hit;
    logic               lim_bad;
    logic               tick;

    assign sum_w = {scan_q[R-1], scan_q} + {2'b00, bus.step};
    assign dif_w = {scan_q[R-1], scan_q} - {2'b00, bus.step};

    satprotect #(.Ri(R + 1), .Ro(R), .SAT(R)) u_sat_up (
        .din  (sum_w),
        .dout (up_sat)
    );

    satprotect #(.Ri(R + 1), .Ro(R), .SAT(R)) u_sat_dn (
        .din  (dif_w),
        .dout (dn_sat)
    );

    assign up_hit  = $signed({up_sat[R-1], up_sat}) >= $signed({bus.hig_lim[R-1], bus.hig_lim});
    assign dn_hit  = $signed({dn_sat[R-1], dn_sat}) <= $signed({bus.low_lim[R-1], bus.low_lim});
    assign lim_bad = $signed(bus.low_lim) > $signed(bus.hig_lim);

    // A divider lowered below the running count still yields a tick when the count wraps.
    assign tick = (cnt_q == bus.divider) || (&cnt_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            scan_q  <= '0;
            trig_q  <= 1'b0;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            scan_q  <= scan_n;
            trig_q  <= trig_n;
            dir_q   <= dir_n;
            err_q   <= err_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state_q;
        scan_n  = scan_q;
        trig_n  = 1'b0;
        dir_n   = dir_q;
        err_n   = 1'b0;
        cnt_n   = cnt_q;

        if (!is_ramp(state_q) || !bus.run_scan) begin
            scan_n  = bus.scan_A;
            cnt_n   = '0;
            dir_n   = 1'b1;
            state_n = ST_IDLE;
            if (state_q == ST_IDLE && bus.run_scan) begin
                state_n = ST_UP;
                err_n   = lim_bad;
            end
        end else begin
            err_n = lim_bad;
            cnt_n = tick ? '0 : cnt_q + DIV_W'(1);
            // Crossed limits freeze the ramp in place until the controller fixes them.
            if (tick && !lim_bad) begin
                if (state_q == ST_UP) begin
                    if (up_hit) begin
                        scan_n  = bus.hig_lim;
                        dir_n   = 1'b0;
                        state_n = ST_DOWN;
                    end else begin
                        scan_n = up_sat;
                    end
                end else begin
                    if (dn_hit) begin
                        scan_n  = bus.low_lim;
                        dir_n   = 1'b1;
                        trig_n  = 1'b1;
                        state_n = ST_UP;
                    end else begin
                        scan_n = dn_sat;
                    end
                end
            end
        end
    end

    assign bus.scan_out     = scan_q;
    assign bus.scan_trigger = trig_q;
    assign bus.scan_dir     = dir_q;
    assign bus.lim_err      = err_q;

endmodule
